net_msg_adapter: RTL

Network endpoint adapter that sits directly upstream and downstream of the test network at one terminal port. It packs client requests into network messages with `{dest, src, opaque, payload}` fields, stamping the local source ID and a rolling opaque tag. It enforces a cap on in-flight messages and unpacks the messages that return from the network's output port back to the client. Both directions are registered val/rdy stages, so the network sees clean registered outputs.

---
 rtl/net_msg_adapter_if.sv | 59 +++++
 rtl/net_msg_adapter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/net_msg_adapter_if.sv
// Client and network handshake bundle for one terminal port of the test network.
// slave is the adapter's view; master is the client/network environment's view.
interface net_msg_adapter_if #(
   parameter int p_payload_nbits   = 32,
   parameter int p_opaque_nbits    = 3,
   parameter int p_srcdest_nbits   = 3,
   parameter int p_max_outstanding = 4
) ();

   localparam int n = 2 * p_srcdest_nbits + p_opaque_nbits + p_payload_nbits;
   localparam int c = $clog2(p_max_outstanding + 1);

   logic                       req_val;
   logic                       req_rdy;
   logic [p_srcdest_nbits-1:0] req_dest;
   logic [p_payload_nbits-1:0] req_payload;

   logic                       net_out_val;
   logic                       net_out_rdy;
   logic [n-1:0]               net_out_msg;

   logic                       net_in_val;
   logic                       net_in_rdy;
   logic [n-1:0]               net_in_msg;

   logic                       resp_val;
   logic                       resp_rdy;
   logic [p_srcdest_nbits-1:0] resp_src;
   logic [p_opaque_nbits-1:0]  resp_opaque;
   logic [p_payload_nbits-1:0] resp_payload;

   logic [c-1:0]               outstanding;
   logic                       err;

   modport slave (
      input  req_val, req_dest, req_payload,
      output req_rdy,
      output net_out_val, net_out_msg,
      input  net_out_rdy,
      input  net_in_val, net_in_msg,
      output net_in_rdy,
      output resp_val, resp_src, resp_opaque, resp_payload,
      input  resp_rdy,
      output outstanding, err
   );

   modport master (
      output req_val, req_dest, req_payload,
      input  req_rdy,
      input  net_out_val, net_out_msg,
      output net_out_rdy,
      output net_in_val, net_in_msg,
      input  net_in_rdy,
      input  resp_val, resp_src, resp_opaque, resp_payload,
      output resp_rdy,
      input  outstanding, err
   );

endinterface

// File: rtl/net_msg_adapter.sv
// Network endpoint adapter: packs client requests into {dest,src,opaque,payload}
// messages with credit limiting, and unpacks returning messages to the client.
module net_msg_adapter #(
   parameter int p_payload_nbits   = 32,
   parameter int p_opaque_nbits    = 3,
   parameter int p_srcdest_nbits   = 3,
   parameter int p_src_id          = 0,
   parameter int p_max_outstanding = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   net_msg_adapter_if.slave      bus
);

   localparam int P = p_payload_nbits;
   localparam int O = p_opaque_nbits;
   localparam int S = p_srcdest_nbits;
   localparam int N = 2 * S + O + P;
   localparam int C = $clog2(p_max_outstanding + 1);

   localparam logic [S-1:0] SRC_ID  = S'(p_src_id);
   localparam logic [C-1:0] MAX_CNT = C'(p_max_outstanding);

   // send path state
   logic         out_full;
   logic [N-1:0] out_msg;
   logic [O-1:0] tag;

   // receive path state
   logic         resp_full;
   logic [S-1:0] resp_src;
   logic [O-1:0] resp_opaque;
   logic [P-1:0] resp_payload;

   logic [C-1:0] count;
   logic         err_q;

   logic         req_rdy_w;
   logic         net_in_rdy_w;
   logic         req_fire;
   logic         out_fire;
   logic         in_fire;
   logic         resp_fire;
   logic         capture;
   logic         drop;

   logic [S-1:0] in_dest;
   logic [S-1:0] in_src;
   logic [O-1:0] in_opaque;
   logic [P-1:0] in_payload;

   assign in_dest    = bus.net_in_msg[N-1 -: S];
   assign in_src     = bus.net_in_msg[N-S-1 -: S];
   assign in_opaque  = bus.net_in_msg[P+O-1 -: O];
   assign in_payload = bus.net_in_msg[P-1:0];

   // Gating with reset keeps req_rdy low while reset is asserted.
   always_comb begin
      req_rdy_w    = reset && (count < MAX_CNT) && (!out_full || bus.net_out_rdy);
      net_in_rdy_w = !resp_full || bus.resp_rdy;
      req_fire     = bus.req_val && req_rdy_w;
      out_fire     = out_full && bus.net_out_rdy;
      in_fire      = bus.net_in_val && net_in_rdy_w;
      resp_fire    = resp_full && bus.resp_rdy;
      capture      = in_fire && (in_dest == SRC_ID) && (count != '0);
      drop         = in_fire && !capture;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_full <= 1'b0;
         out_msg  <= '0;
         tag      <= '0;
      end else if (req_fire) begin
         out_full <= 1'b1;
         out_msg  <= {bus.req_dest, SRC_ID, tag, bus.req_payload};
         tag      <= tag + O'(1);
      end else if (out_fire) begin
         out_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_full    <= 1'b0;
         resp_src     <= '0;
         resp_opaque  <= '0;
         resp_payload <= '0;
      end else if (capture) begin
         resp_full    <= 1'b1;
         resp_src     <= in_src;
         resp_opaque  <= in_opaque;
         resp_payload <= in_payload;
      end else if (resp_fire) begin
         resp_full    <= 1'b0;
      end
   end

   // Simultaneous send and capture cancel out and leave the credit count alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (req_fire && !capture) begin
         count <= count + C'(1);
      end else if (capture && !req_fire) begin
         count <= count - C'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (drop) begin
         err_q <= 1'b1;
      end
   end

   assign bus.req_rdy      = req_rdy_w;
   assign bus.net_out_val  = out_full;
   assign bus.net_out_msg  = out_msg;
   assign bus.net_in_rdy   = net_in_rdy_w;
   assign bus.resp_val     = resp_full;
   assign bus.resp_src     = resp_src;
   assign bus.resp_opaque  = resp_opaque;
   assign bus.resp_payload = resp_payload;
   assign bus.outstanding  = count;
   assign bus.err          = err_q;

   a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
      count <= MAX_CNT);

   a_out_held: assert property (@(posedge clk) disable iff (!reset)
      out_full && !bus.net_out_rdy |=> out_full && $stable(out_msg));

   a_resp_held: assert property (@(posedge clk) disable iff (!reset)
      resp_full && !bus.resp_rdy |=> resp_full && $stable({resp_src, resp_opaque, resp_payload}));

endmodule
